// File: rtl/mem_bank_group_arbiter.sv
// Arbitrates one wide bank group between per-sub-bank narrow ports and a single wide port,
// with bounded wide starvation and fixed-latency response steering back to the granted side.
module mem_bank_group_arbiter #(
   parameter int unsigned NumSubBanks = 4,
   parameter int unsigned MaxStarve   = 3,
   parameter int unsigned RspLatency  = 2,
   parameter int unsigned CntWidth    = 32,
   localparam int unsigned StarveW    = $clog2(MaxStarve + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumSubBanks-1:0] narrow_req_i,
   output logic [NumSubBanks-1:0] narrow_gnt_o,
   output logic [NumSubBanks-1:0] narrow_rvalid_o,
   input  logic                   wide_req_i,
   output logic                   wide_gnt_o,
   output logic                   wide_rvalid_o,
   output logic [NumSubBanks-1:0] bank_req_o,
   output logic [NumSubBanks-1:0] bank_sel_wide_o,
   input  logic                   cfg_wide_prio_i,
   output logic [StarveW-1:0]     starve_cnt_o,
   output logic [CntWidth-1:0]    wide_stall_cnt_o
);

   localparam logic [StarveW-1:0] StarveMax = StarveW'(MaxStarve);

   logic [StarveW-1:0]     starve_q, starve_d;
   logic [CntWidth-1:0]    stall_q, stall_d;
   logic [NumSubBanks-1:0] narrow_pipe_q [RspLatency];
   logic                   wide_pipe_q   [RspLatency];
   logic                   wide_win;
   logic                   wide_stall;

   assign wide_win   = wide_req_i & (cfg_wide_prio_i | ~|narrow_req_i | (starve_q == StarveMax));
   assign wide_stall = wide_req_i & ~wide_win;

   // Reset masks grants combinationally so nothing reaches the SRAMs while reset is held.
   always_comb begin
      narrow_gnt_o    = '0;
      wide_gnt_o      = 1'b0;
      bank_req_o      = '0;
      bank_sel_wide_o = '0;
      if (!rst_i) begin
         if (wide_win) begin
            wide_gnt_o      = 1'b1;
            bank_req_o      = '1;
            bank_sel_wide_o = '1;
         end else begin
            narrow_gnt_o = narrow_req_i;
            bank_req_o   = narrow_req_i;
         end
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (!wide_stall) begin
         starve_d = '0;
      end else if (starve_q != StarveMax) begin
         starve_d = starve_q + 1'b1;
      end
      stall_d = stall_q;
      if (wide_stall && !(&stall_q)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_q <= '0;
         stall_q  <= '0;
         for (int i = 0; i < RspLatency; i++) begin
            narrow_pipe_q[i] <= '0;
            wide_pipe_q[i]   <= 1'b0;
         end
      end else begin
         starve_q         <= starve_d;
         stall_q          <= stall_d;
         narrow_pipe_q[0] <= narrow_gnt_o;
         wide_pipe_q[0]   <= wide_gnt_o;
         for (int i = 1; i < RspLatency; i++) begin
            narrow_pipe_q[i] <= narrow_pipe_q[i-1];
            wide_pipe_q[i]   <= wide_pipe_q[i-1];
         end
      end
   end

   assign narrow_rvalid_o  = narrow_pipe_q[RspLatency-1];
   assign wide_rvalid_o    = wide_pipe_q[RspLatency-1];
   assign starve_cnt_o     = starve_q;
   assign wide_stall_cnt_o = stall_q;

endmodule

// File: tb/tb_mem_bank_group_arbiter.sv
// Directed bench for mem_bank_group_arbiter: grant decisions, starvation bound,
// response steering and mid-flight reset, all against hand-computed values.
module tb_mem_bank_group_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  narrow_req_i;
   logic [3:0]  narrow_gnt_o;
   logic [3:0]  narrow_rvalid_o;
   logic        wide_req_i;
   logic        wide_gnt_o;
   logic        wide_rvalid_o;
   logic [3:0]  bank_req_o;
   logic [3:0]  bank_sel_wide_o;
   logic        cfg_wide_prio_i;
   logic [1:0]  starve_cnt_o;
   logic [31:0] wide_stall_cnt_o;

   int checks   = 0;
   int failures = 0;

   mem_bank_group_arbiter #(
      .NumSubBanks(4), .MaxStarve(3), .RspLatency(2), .CntWidth(32)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .narrow_req_i(narrow_req_i), .narrow_gnt_o(narrow_gnt_o), .narrow_rvalid_o(narrow_rvalid_o),
      .wide_req_i(wide_req_i), .wide_gnt_o(wide_gnt_o), .wide_rvalid_o(wide_rvalid_o),
      .bank_req_o(bank_req_o), .bank_sel_wide_o(bank_sel_wide_o),
      .cfg_wide_prio_i(cfg_wide_prio_i), .starve_cnt_o(starve_cnt_o),
      .wide_stall_cnt_o(wide_stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply inputs one time unit after the edge and let combinational outputs settle.
   task automatic drive(input logic rst, input logic [3:0] nreq, input logic wreq, input logic prio);
      rst_i = rst; narrow_req_i = nreq; wide_req_i = wreq; cfg_wide_prio_i = prio;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_grants(input string tag, input logic [3:0] ngnt, input logic wgnt,
                               input logic [3:0] breq, input logic [3:0] bsel);
      check({tag, ".narrow_gnt"}, 64'(narrow_gnt_o), 64'(ngnt));
      check({tag, ".wide_gnt"}, 64'(wide_gnt_o), 64'(wgnt));
      check({tag, ".bank_req"}, 64'(bank_req_o), 64'(breq));
      check({tag, ".bank_sel"}, 64'(bank_sel_wide_o), 64'(bsel));
   endtask

   task automatic check_rsp(input string tag, input logic [3:0] nrv, input logic wrv);
      check({tag, ".narrow_rvalid"}, 64'(narrow_rvalid_o), 64'(nrv));
      check({tag, ".wide_rvalid"}, 64'(wide_rvalid_o), 64'(wrv));
   endtask

   logic [1:0] exp_starve [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
   logic       exp_wgnt   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      // Reset held while requests are present: grants must be masked.
      drive(1'b1, 4'b1111, 1'b1, 1'b0);
      check_grants("rst_mask", 4'b0, 1'b0, 4'b0, 4'b0);
      tick(); tick();
      drive(1'b0, 4'b0, 1'b0, 1'b0);
      check_grants("post_rst", 4'b0, 1'b0, 4'b0, 4'b0);
      check_rsp("post_rst", 4'b0, 1'b0);
      check("post_rst.starve", 64'(starve_cnt_o), 64'd0);
      check("post_rst.stall", 64'(wide_stall_cnt_o), 64'd0);
      tick();

      // Narrow only.
      drive(1'b0, 4'b0101, 1'b0, 1'b0);
      check_grants("narrow", 4'b0101, 1'b0, 4'b0101, 4'b0);
      tick();
      drive(1'b0, 4'b0, 1'b0, 1'b0);
      check_rsp("narrow_c1", 4'b0, 1'b0);
      tick();
      check_rsp("narrow_c2", 4'b0101, 1'b0);
      tick();
      check_rsp("narrow_c3", 4'b0, 1'b0);

      // Wide on an idle group.
      drive(1'b0, 4'b0, 1'b1, 1'b0);
      check_grants("wide_idle", 4'b0, 1'b1, 4'b1111, 4'b1111);
      check("wide_idle.starve", 64'(starve_cnt_o), 64'd0);
      tick();
      drive(1'b0, 4'b0, 1'b0, 1'b0);
      check_rsp("wide_idle_c1", 4'b0, 1'b0);
      check("wide_idle_c1.starve", 64'(starve_cnt_o), 64'd0);
      tick();
      check_rsp("wide_idle_c2", 4'b0, 1'b1);
      tick();

      // Starvation: wide + narrow 0001 held six cycles.
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, 4'b0001, 1'b1, 1'b0);
         check($sformatf("starve_c%0d.cnt", c), 64'(starve_cnt_o), 64'(exp_starve[c]));
         check($sformatf("starve_c%0d.wide_gnt", c), 64'(wide_gnt_o), 64'(exp_wgnt[c]));
         check($sformatf("starve_c%0d.narrow_gnt", c), 64'(narrow_gnt_o),
               exp_wgnt[c] ? 64'd0 : 64'd1);
         if (c == 5) check("starve_c5.stall", 64'(wide_stall_cnt_o), 64'd4);
         tick();
      end
      drive(1'b0, 4'b0, 1'b0, 1'b0);
      check("starve_end.stall", 64'(wide_stall_cnt_o), 64'd5);
      check("starve_end.starve", 64'(starve_cnt_o), 64'd2);
      tick();
      check("starve_idle.starve", 64'(starve_cnt_o), 64'd0);
      tick();

      // Priority override: wide wins every cycle and never stalls.
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 4'b1111, 1'b1, 1'b1);
         check_grants($sformatf("prio_c%0d", c), 4'b0, 1'b1, 4'b1111, 4'b1111);
         check($sformatf("prio_c%0d.stall", c), 64'(wide_stall_cnt_o), 64'd5);
         tick();
      end
      // Dropping prio takes effect in the same cycle.
      drive(1'b0, 4'b1111, 1'b1, 1'b0);
      check_grants("prio_off", 4'b1111, 1'b0, 4'b1111, 4'b0);
      tick();
      drive(1'b0, 4'b0, 1'b0, 1'b0);
      check("prio_off.stall", 64'(wide_stall_cnt_o), 64'd6);
      tick(); tick(); tick();
      check_rsp("drain", 4'b0, 1'b0);

      // Interleaved narrow / wide / narrow grants.
      drive(1'b0, 4'b1000, 1'b0, 1'b0);
      check_rsp("ilv_c0", 4'b0, 1'b0);
      tick();
      drive(1'b0, 4'b0, 1'b1, 1'b0);
      check_grants("ilv_c1", 4'b0, 1'b1, 4'b1111, 4'b1111);
      check_rsp("ilv_c1", 4'b0, 1'b0);
      tick();
      drive(1'b0, 4'b0010, 1'b0, 1'b0);
      check_rsp("ilv_c2", 4'b1000, 1'b0);
      tick();
      drive(1'b0, 4'b0, 1'b0, 1'b0);
      check_rsp("ilv_c3", 4'b0, 1'b1);
      tick();
      check_rsp("ilv_c4", 4'b0010, 1'b0);
      tick();
      check_rsp("ilv_c5", 4'b0, 1'b0);

      // Reset while a wide response is in flight.
      drive(1'b0, 4'b0, 1'b1, 1'b0);
      check("rmf_c0.wide_gnt", 64'(wide_gnt_o), 64'd1);
      tick();
      drive(1'b1, 4'b0001, 1'b1, 1'b0);
      check_grants("rmf_c1", 4'b0, 1'b0, 4'b0, 4'b0);
      tick();
      drive(1'b0, 4'b0, 1'b0, 1'b0);
      check_rsp("rmf_c2", 4'b0, 1'b0);
      check("rmf_c2.starve", 64'(starve_cnt_o), 64'd0);
      check("rmf_c2.stall", 64'(wide_stall_cnt_o), 64'd0);
      tick();
      check_rsp("rmf_c3", 4'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
